hs4_sink: RTL

Clocked receiving end of the four-phase bundled-data request/acknowledge channel driven by the asynchronous memory-stage latch controllers. Synchronises the incoming request, captures the bundled data word, returns the acknowledge, and buffers the words in a small FIFO. The FIFO is drained through a valid/ready stream port into the synchronous part of the SoC. Back-pressure is applied by withholding the acknowledge when the FIFO is full.

---
 rtl/hs4_pkg.sv | 13 +
 rtl/hs4_fifo.sv | 57 +++++
 rtl/hs4_sink.sv | 87 ++++++++
 3 files changed

// File: rtl/hs4_pkg.sv
// Shared types and parameter defaults for the four-phase bundled-data sink.
package hs4_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } hs4_state_t;

  localparam int DATA_W_DEF      = 8;
  localparam int DEPTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/hs4_fifo.sv
// Circular-buffer FIFO with a separate occupancy counter; the head word is read
// straight out of the register array, so a push into an empty FIFO is visible next cycle.
module hs4_fifo
  import hs4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!i_push && i_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/hs4_sink.sv
// Clocked receiver for the four-phase req/ack channel: synchronises req_i,
// captures the bundled word into a FIFO and withholds ack_o while the FIFO is full.
module hs4_sink
  import hs4_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     ack_o,
  output logic                     m_valid_o,
  output logic [DATA_W-1:0]        m_data_o,
  input  logic                     m_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_req_s;
  hs4_state_t             r_state;
  hs4_state_t             w_state_next;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req_i};
    end
  end

  // Only the synchronised request drives decisions; raw req_i may be metastable.
  assign w_req_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_s && !w_full) begin
          w_push       = 1'b1;
          w_state_next = S_ACK;
        end
      end
      S_ACK: begin
        if (!w_req_s) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign ack_o     = (r_state == S_ACK);
  assign m_valid_o = !w_empty;
  assign w_pop     = m_valid_o && m_ready_i;

  hs4_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (data_i),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count_o),
    .o_data  (m_data_o)
  );

endmodule
